pudding_chain_tx: RTL and testbench

Host-side serial frame generator for the PUDDING DAC daisy chain. Takes a WIDTH-bit DAC code through a valid/ready handshake and drives the loader's `datum`/`shift`/`transfer`/`dir` pins:
- shifts the code MSB-first into the chain;
- issues one commit pulse that moves it from the daisy chain to the DAC state register.

An optional readback mode captures the state into the chain and serialises it back from the chain tail. The block sits between the on-chip configuration source and the `ui_in[3:0]` loader controls of `heichips25_pudding`.

---
 rtl/pudding_chain_tx.sv | 160 ++++++++++++++++
 tb/tb_pudding_chain_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pudding_chain_tx.sv
// rtl/pudding_chain_tx.sv - serial frame generator for the PUDDING DAC daisy chain
// Optional readback (CAPTURE/READ) is enabled by defining PUDDING_CHAIN_READBACK_EN.
module pudding_chain_tx #(
    parameter int WIDTH = 128,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    input  logic             tx_rd,
    output logic             tx_ready,
    output logic             busy,
    output logic             datum,
    output logic             shift,
    output logic             transfer,
    output logic             dir,
    input  logic             rb_in,
    output logic [WIDTH-1:0] rb_data,
    output logic             rb_valid
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PEN  = (DIV > 1) ? DIV_W'(DIV - 2) : '0;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic FIRST_SHIFT = (DIV == 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_COMMIT  = 3'd2;
`ifdef PUDDING_CHAIN_READBACK_EN
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
`endif

    logic [2:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             period_end;
    logic             last_bit;

    assign period_end = (div_cnt == DIV_LAST);
    assign last_bit   = (bit_cnt == BIT_LAST);

`ifndef PUDDING_CHAIN_READBACK_EN
    logic unused_inputs;
    assign unused_inputs = ^{tx_rd, rb_in};
`endif

    // Outputs are registered and loaded with the value for the coming cycle,
    // so the cycle right after acceptance already shows the first bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sreg     <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            datum    <= 1'b0;
            shift    <= 1'b0;
            transfer <= 1'b0;
            dir      <= 1'b0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!tx_ready) begin
                        // trailing cycle after a readback while rb_valid is shown
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else if (tx_valid) begin
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        sreg     <= tx_data;
`ifdef PUDDING_CHAIN_READBACK_EN
                        if (tx_rd) begin
                            state    <= S_CAPTURE;
                            datum    <= 1'b0;
                            transfer <= 1'b1;
                            dir      <= 1'b0;
                        end else begin
                            state <= S_SHIFT;
                            datum <= tx_data[WIDTH-1];
                            shift <= FIRST_SHIFT;
                        end
`else
                        state <= S_SHIFT;
                        datum <= tx_data[WIDTH-1];
                        shift <= FIRST_SHIFT;
`endif
                    end
                end
                S_SHIFT: begin
                    if (period_end) begin
                        sreg    <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        div_cnt <= '0;
                        if (last_bit) begin
                            state    <= S_COMMIT;
                            shift    <= 1'b0;
                            datum    <= 1'b0;
                            transfer <= 1'b1;
                            dir      <= 1'b1;
                        end else begin
                            datum <= sreg[WIDTH-2];
                            shift <= FIRST_SHIFT;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        shift   <= (div_cnt == DIV_PEN);
                    end
                end
                S_COMMIT: begin
                    state    <= S_IDLE;
                    transfer <= 1'b0;
                    dir      <= 1'b0;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
`ifdef PUDDING_CHAIN_READBACK_EN
                S_CAPTURE: begin
                    state    <= S_READ;
                    transfer <= 1'b0;
                    shift    <= FIRST_SHIFT;
                end
                S_READ: begin
                    if (period_end) begin
                        // sample the chain tail before it moves on this shift edge
                        rb_data <= {rb_data[WIDTH-2:0], rb_in};
                        bit_cnt <= bit_cnt + 1'b1;
                        div_cnt <= '0;
                        if (last_bit) begin
                            state    <= S_IDLE;
                            shift    <= 1'b0;
                            rb_valid <= 1'b1;
                        end else begin
                            shift <= FIRST_SHIFT;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                        shift   <= (div_cnt == DIV_PEN);
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pudding_chain_tx.sv
// tb/tb_pudding_chain_tx.sv - self-checking bench for pudding_chain_tx
// Three DUTs (DIV 1, 3, 2) each drive a behavioural daisy-chain/state model.
module tb_pudding_chain_tx;

    localparam int W = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] tx_data [3];
    logic         tx_valid [3];
    logic         tx_rd [3];
    logic         rdy [3];
    logic         bsy [3];
    logic         dat [3];
    logic         shf [3];
    logic         xfr [3];
    logic         dr [3];
    logic         rbi [3];
    logic         rbv [3];
    logic [W-1:0] rbd [3];

    logic [W-1:0] chain [3] = '{default: '0};
    logic [W-1:0] dac [3]   = '{default: '0};
    int           xfers [3] = '{default: 0};

    int checks = 0;
    int errors = 0;
    int last_wait;
    int last_dhigh;

    for (genvar g = 0; g < 3; g++) begin : u
        pudding_chain_tx #(.WIDTH(W), .DIV(g == 0 ? 1 : (g == 1 ? 3 : 2))) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .tx_data (tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_rd   (tx_rd[g]),
            .tx_ready(rdy[g]),
            .busy    (bsy[g]),
            .datum   (dat[g]),
            .shift   (shf[g]),
            .transfer(xfr[g]),
            .dir     (dr[g]),
            .rb_in   (rbi[g]),
            .rb_data (rbd[g]),
            .rb_valid(rbv[g])
        );
        assign rbi[g] = chain[g][W-1];
    end

    // External chain: shift pushes datum in at bit 0; transfer moves chain<->state.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (shf[i] === 1'b1) chain[i] <= {chain[i][W-2:0], dat[i]};
            if (xfr[i] === 1'b1) begin
                xfers[i] <= xfers[i] + 1;
                if (dr[i] === 1'b1) dac[i] <= chain[i];
                else chain[i] <= dac[i];
            end
        end
    end

    function automatic int div_of(input int unit);
        return (unit == 0) ? 1 : ((unit == 1) ? 3 : 2);
    endfunction

    function automatic logic [W-1:0] rnd_code();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_write(input int unit, input logic [W-1:0] code, input bit hold,
                             input logic [W-1:0] next_code, input bit rd, input string name);
        int d = div_of(unit);
        int n = W * d;
        int w = 0;
        int x0;
        int e_shift = 0, e_datum = 0, e_xfer = 0, e_ready = 0, e_rbv = 0, n_shift = 0;
        bit exp_shift, exp_xfer, exp_datum, exp_ready;
        last_dhigh = 0;
        tx_data[unit] = code;
        tx_rd[unit] = rd;
        tx_valid[unit] = 1'b1;
        while (rdy[unit] !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        checks++;
        if (w >= 2000) begin
            errors++;
            $display("FAIL %s accept timeout: waited %0d cycles", name, w);
            tx_valid[unit] = 1'b0;
            return;
        end
        x0 = xfers[unit];
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) tx_data[unit] = next_code;
                else tx_valid[unit] = 1'b0;
                tx_rd[unit] = 1'b0;
            end
            exp_shift = (c <= n) && (c % d == 0);
            exp_xfer  = (c == n + 1);
            exp_datum = (c <= n) ? code[W-1-(c-1)/d] : 1'b0;
            exp_ready = (c == n + 2);
            if (shf[unit] !== exp_shift) e_shift++;
            if (shf[unit] === 1'b1) n_shift++;
            if (dat[unit] !== exp_datum) e_datum++;
            if (dat[unit] === 1'b1) last_dhigh++;
            if (xfr[unit] !== exp_xfer || (exp_xfer && dr[unit] !== 1'b1)) e_xfer++;
            if (rdy[unit] !== exp_ready || bsy[unit] !== !exp_ready) e_ready++;
            if (rbv[unit] !== 1'b0) e_rbv++;
        end
        checks++; if (e_shift !== 0) begin errors++; $display("FAIL %s shift timing: %0d bad cycles, want 0", name, e_shift); end
        checks++; if (n_shift !== W) begin errors++; $display("FAIL %s shift count: got %0d want %0d", name, n_shift, W); end
        checks++; if (e_datum !== 0) begin errors++; $display("FAIL %s datum: %0d bad cycles, want 0", name, e_datum); end
        checks++; if (e_xfer !== 0) begin errors++; $display("FAIL %s commit: %0d bad cycles, want 0", name, e_xfer); end
        checks++; if (e_ready !== 0) begin errors++; $display("FAIL %s ready/busy: %0d bad cycles, want 0", name, e_ready); end
        checks++; if (e_rbv !== 0) begin errors++; $display("FAIL %s rb_valid: %0d pulses, want 0", name, e_rbv); end
        checks++; if (xfers[unit] - x0 !== 1) begin errors++; $display("FAIL %s transfer count: got %0d want 1", name, xfers[unit] - x0); end
        checks++; if (dac[unit] !== code) begin errors++; $display("FAIL %s state: got %h want %h", name, dac[unit], code); end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tx_valid[i] = 1'b0;
            tx_rd[i] = 1'b0;
            tx_data[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rdy[i], bsy[i], dat[i], shf[i], xfr[i], dr[i], rbv[i]} !== 7'b1000000 || rbd[i] !== '0) begin
                errors++;
                $display("FAIL reset unit%0d: ctl=%b rb_data=%h want ctl=1000000 rb_data=0", i,
                         {rdy[i], bsy[i], dat[i], shf[i], xfr[i], dr[i], rbv[i]}, rbd[i]);
            end
        end
    endtask

    task automatic test_write_div1();
        logic [W-1:0] code = '0;
        code[W-1] = 1'b1;
        code[0] = 1'b1;
        run_write(0, code, 1'b0, '0, 1'b0, "div1");
        checks++;
        if (last_dhigh !== 2) begin errors++; $display("FAIL div1 datum-high cycles: got %0d want 2", last_dhigh); end
    endtask

    task automatic test_write_div3();
        run_write(1, rnd_code(), 1'b0, '0, 1'b0, "div3");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a = rnd_code();
        logic [W-1:0] b = rnd_code();
        run_write(0, a, 1'b1, b, 1'b0, "b2b_first");
        run_write(0, b, 1'b0, '0, 1'b0, "b2b_second");
        checks++;
        if (last_wait !== 0) begin errors++; $display("FAIL b2b bubble: second accept after %0d waits, want 0", last_wait); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] prev = dac[0];
        int x0 = xfers[0];
        tx_data[0] = rnd_code();
        tx_valid[0] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) tx_valid[0] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy[0], bsy[0], dat[0], shf[0], xfr[0], dr[0], rbv[0]} !== 7'b1000000 || rbd[0] !== '0) begin
            errors++;
            $display("FAIL async reset: ctl=%b rb_data=%h want ctl=1000000 rb_data=0",
                     {rdy[0], bsy[0], dat[0], shf[0], xfr[0], dr[0], rbv[0]}, rbd[0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL post-reset ready: got %b want 1", rdy[0]); end
        checks++;
        if (xfers[0] !== x0 || dac[0] !== prev) begin
            errors++;
            $display("FAIL reset commit: transfers %0d want %0d, state %h want %h", xfers[0], x0, dac[0], prev);
        end
        run_write(0, rnd_code(), 1'b0, '0, 1'b0, "post_reset");
    endtask

`ifdef PUDDING_CHAIN_READBACK_EN
    task automatic test_readback(input logic [W-1:0] code, input string name);
        int d = div_of(2);
        int n = W * d;
        int w = 0;
        int e_shift = 0, e_datum = 0, e_xfer = 0, e_ready = 0, e_rbv = 0, n_shift = 0;
        logic [W-1:0] got = '0;
        bit exp_shift;
        run_write(2, code, 1'b0, '0, 1'b0, name);
        tx_data[2] = rnd_code();
        tx_rd[2] = 1'b1;
        tx_valid[2] = 1'b1;
        while (rdy[2] !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 2000) begin errors++; $display("FAIL %s readback accept timeout", name); tx_valid[2] = 1'b0; return; end
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tx_valid[2] = 1'b0;
                tx_rd[2] = 1'b0;
            end
            exp_shift = (c >= 2) && (c <= n + 1) && ((c - 1) % d == 0);
            if (shf[2] !== exp_shift) e_shift++;
            if (shf[2] === 1'b1) n_shift++;
            if (dat[2] !== 1'b0) e_datum++;
            if (xfr[2] !== (c == 1) || (c == 1 && dr[2] !== 1'b0)) e_xfer++;
            if (rbv[2] !== (c == n + 2)) e_rbv++;
            if (rbv[2] === 1'b1) got = rbd[2];
            if (rdy[2] !== (c == n + 3) || bsy[2] !== (c != n + 3)) e_ready++;
        end
        checks++; if (e_xfer !== 0) begin errors++; $display("FAIL %s capture: %0d bad cycles, want 0", name, e_xfer); end
        checks++; if (e_shift !== 0 || n_shift !== W) begin errors++; $display("FAIL %s rb shift: %0d bad, %0d pulses, want 0/%0d", name, e_shift, n_shift, W); end
        checks++; if (e_datum !== 0) begin errors++; $display("FAIL %s rb datum: %0d bad cycles, want 0", name, e_datum); end
        checks++; if (e_rbv !== 0) begin errors++; $display("FAIL %s rb_valid: %0d bad cycles, want 0", name, e_rbv); end
        checks++; if (e_ready !== 0) begin errors++; $display("FAIL %s rb ready: %0d bad cycles, want 0", name, e_ready); end
        checks++; if (got !== code) begin errors++; $display("FAIL %s rb_data: got %h want %h", name, got, code); end
        checks++; if (dac[2] !== code) begin errors++; $display("FAIL %s state after rb: got %h want %h", name, dac[2], code); end
        checks++; if (chain[2] !== '0) begin errors++; $display("FAIL %s chain after rb: got %h want 0", name, chain[2]); end
    endtask
`else
    task automatic test_rd_ignored();
        run_write(2, rnd_code(), 1'b0, '0, 1'b1, "rd_ignored");
        checks++;
        if (rbd[2] !== '0) begin errors++; $display("FAIL rd_ignored rb_data: got %h want 0", rbd[2]); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_div1();
        test_write_div3();
        test_back_to_back();
        test_reset_mid();
`ifdef PUDDING_CHAIN_READBACK_EN
        test_readback({16{8'hA5}}, "rb_a5");
        test_readback(rnd_code(), "rb_rand");
`else
        test_rd_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
